// File: rtl/lsu_bridge.sv
// Load/store bridge between the RV32I core data port and multi-cycle memory.
// Formats sizes, drives core stall, flags misaligned accesses and timeouts.
//
// Ports:
//   clk, reset         clock (rising edge), async active-high reset
//   core_re/core_we    load / store request (store wins if both)
//   core_funct3        access size and sign
//   core_addr          byte address
//   core_wdata         store data (rs2)
//   core_rdata         extended load data, valid while done=1
//   stall              hold PC and register write
//   done               one-cycle retire pulse
//   misalign           misaligned or illegal-size access
//   timeout_err        pulse with done when the access timed out
//   mem_req/mem_we     memory request / write select
//   mem_addr           word address
//   mem_wdata/wstrb    lane-replicated store data and byte enables
//   mem_ack/mem_rdata  memory completion and read word
module lsu_bridge #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        core_re,
   input  logic        core_we,
   input  logic [2:0]  core_funct3,
   input  logic [31:0] core_addr,
   input  logic [31:0] core_wdata,
   output logic [31:0] core_rdata,
   output logic        stall,
   output logic        done,
   output logic        misalign,
   output logic        timeout_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      DONE
   } state_t;

   state_t state, state_nx;

   logic             acc;
   logic             start;
   logic             to_hit;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       off_q;
   logic [2:0]       f3_q;
   logic             to_q;
   logic [31:0]      rdata_q;
   logic [31:0]      st_wdata;
   logic [3:0]       st_wstrb;
   logic [31:0]      ld_data;
   logic [31:0]      lane;

   assign acc    = core_re | core_we;
   assign start  = acc & ~misalign;
   assign to_hit = (cnt == CNT_W'(TIMEOUT - 1));

   always_comb begin
      misalign = 1'b0;
      case (core_funct3)
         3'b000, 3'b100: misalign = 1'b0;
         3'b001, 3'b101: misalign = core_addr[0];
         3'b010:         misalign = |core_addr[1:0];
         default:        misalign = 1'b1;
      endcase
      misalign = misalign & acc;
   end

   always_comb begin
      st_wdata = core_wdata;
      st_wstrb = 4'b1111;
      case (core_funct3[1:0])
         2'b00: begin
            st_wdata = {4{core_wdata[7:0]}};
            st_wstrb = 4'b0001 << core_addr[1:0];
         end
         2'b01: begin
            st_wdata = {2{core_wdata[15:0]}};
            st_wstrb = core_addr[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            st_wdata = core_wdata;
            st_wstrb = 4'b1111;
         end
      endcase
   end

   // Lane select uses the registered offset; the core address may
   // have moved on while the request is outstanding.
   always_comb begin
      lane    = mem_rdata >> {off_q, 3'b000};
      ld_data = mem_rdata;
      case (f3_q[1:0])
         2'b00:
            ld_data = {{24{~f3_q[2] & lane[7]}}, lane[7:0]};
         2'b01:
            ld_data = {{16{~f3_q[2] & lane[15]}}, lane[15:0]};
         default:
            ld_data = mem_rdata;
      endcase
   end

   always_comb begin
      state_nx    = state;
      stall       = 1'b0;
      done        = 1'b0;
      timeout_err = 1'b0;
      mem_req     = 1'b0;
      core_rdata  = 32'h0;
      case (state)
         IDLE: begin
            stall = start;
            if (start)
               state_nx = REQ;
         end
         REQ: begin
            stall   = 1'b1;
            mem_req = 1'b1;
            if (mem_ack || to_hit)
               state_nx = DONE;
         end
         DONE: begin
            done        = 1'b1;
            timeout_err = to_q;
            core_rdata  = rdata_q;
            state_nx    = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      // Reset releases the core at once, not at the next edge.
      stall = stall & ~reset;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         mem_we    <= 1'b0;
         mem_addr  <= 32'h0;
         mem_wdata <= 32'h0;
         mem_wstrb <= 4'b0000;
         cnt       <= '0;
         off_q     <= 2'b00;
         f3_q      <= 3'b000;
         to_q      <= 1'b0;
         rdata_q   <= 32'h0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: begin
               if (start) begin
                  mem_addr  <= {core_addr[31:2], 2'b00};
                  mem_we    <= core_we;
                  mem_wdata <= core_we ? st_wdata : 32'h0;
                  mem_wstrb <= core_we ? st_wstrb : 4'b0000;
                  cnt       <= '0;
                  off_q     <= core_addr[1:0];
                  f3_q      <= core_funct3;
                  to_q      <= 1'b0;
               end
            end
            REQ: begin
               cnt <= cnt + 1'b1;
               if (mem_ack) begin
                  rdata_q <= mem_we ? 32'h0 : ld_data;
               end else if (to_hit) begin
                  rdata_q <= 32'h0;
                  to_q    <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_bridge.sv
// Self-checking bench for lsu_bridge: directed table, corner
// sequences and randomized accesses against a byte-level model.
module tb_lsu_bridge;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        core_re, core_we;
   logic [2:0]  core_funct3;
   logic [31:0] core_addr, core_wdata, core_rdata;
   logic        stall, done, misalign, timeout_err;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   lsu_bridge #(.TIMEOUT(TO), .CNT_W(16)) dut (
      .clk(clk), .reset(reset),
      .core_re(core_re), .core_we(core_we),
      .core_funct3(core_funct3), .core_addr(core_addr),
      .core_wdata(core_wdata), .core_rdata(core_rdata),
      .stall(stall), .done(done), .misalign(misalign),
      .timeout_err(timeout_err),
      .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata)
   );

   typedef struct {
      string       nm;
      logic        re, we;
      logic [2:0]  f3;
      logic [31:0] addr, wd, rd;
      int          dly;
      logic        emis;
      logic [31:0] ewd;
      logic [3:0]  es;
      logic [31:0] erd;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Byte-level reference: size in bytes, offset within the word.
   task automatic model(input logic re, we, input logic [2:0] f3,
                        input logic [31:0] a, wd, rd,
                        output logic mis, output logic [31:0] ewd,
                        output logic [3:0] es, output logic [31:0] erd);
      int nb, off;
      logic [63:0] v, m;
      logic legal;
      off   = int'(a[1:0]);
      nb    = 1 << f3[1:0];
      legal = (f3 == 0) || (f3 == 1) || (f3 == 2) ||
              (f3 == 4) || (f3 == 5);
      mis   = (re | we) && (!legal || (off % nb) != 0);
      ewd   = 0;
      es    = 0;
      erd   = 0;
      if (!legal) return;
      if (we)
         for (int i = 0; i < 4; i++) begin
            ewd[8*i +: 8] = wd[8*(i % nb) +: 8];
            if (i >= off && i < off + nb) es[i] = 1'b1;
         end
      m = (64'd1 << (8 * nb)) - 1;
      v = (64'(rd) >> (8 * off)) & m;
      if (!f3[2] && v[8*nb-1]) v = v | ~m;
      erd = v[31:0];
   endtask

   task automatic access(input vec_t t);
      int   reqc;
      logic to;
      @(negedge clk);
      core_re     = t.re;
      core_we     = t.we;
      core_funct3 = t.f3;
      core_addr   = t.addr;
      core_wdata  = t.wd;
      mem_ack     = 1'b0;
      #1;
      chk({t.nm, " misalign"}, 32'(misalign), 32'(t.emis));
      chk({t.nm, " idle stall"}, 32'(stall), 32'(!t.emis));
      if (t.emis) begin
         chk({t.nm, " mis req"}, 32'(mem_req), 0);
         if (!t.we)
            chk({t.nm, " mis rdata"}, core_rdata, 0);
         @(posedge clk);
         #1;
         chk({t.nm, " mis req2"}, 32'(mem_req), 0);
         chk({t.nm, " mis done"}, 32'(done), 0);
         core_re = 1'b0;
         core_we = 1'b0;
         return;
      end
      reqc = 0;
      while (1) begin
         @(negedge clk);
         mem_ack = 1'b0;
         if (!mem_req) break;
         reqc++;
         if (reqc == 1) begin
            chk({t.nm, " addr"}, mem_addr, t.addr & ~32'h3);
            chk({t.nm, " we"}, 32'(mem_we), 32'(t.we));
            chk({t.nm, " wdata"}, mem_wdata, t.ewd);
            chk({t.nm, " wstrb"}, 32'(mem_wstrb), 32'(t.es));
         end
         chk({t.nm, " req stall"}, 32'(stall), 1);
         core_re     = 1'($urandom);
         core_we     = 1'($urandom);
         core_funct3 = 3'($urandom);
         core_addr   = $urandom;
         core_wdata  = $urandom;
         if (reqc == t.dly) begin
            mem_ack   = 1'b1;
            mem_rdata = t.rd;
         end else begin
            mem_rdata = $urandom;
         end
         if (reqc > 60) begin
            chk({t.nm, " req bound"}, 32'(reqc), 32'(TO));
            break;
         end
      end
      to = (t.dly == 0);
      chk({t.nm, " req cycles"}, 32'(reqc), to ? TO : t.dly);
      chk({t.nm, " done"}, 32'(done), 1);
      chk({t.nm, " timeout"}, 32'(timeout_err), 32'(to));
      chk({t.nm, " done stall"}, 32'(stall), 0);
      if (t.re && !t.we)
         chk({t.nm, " rdata"}, core_rdata, to ? 32'h0 : t.erd);
      core_re = 1'b0;
      core_we = 1'b0;
   endtask

   vec_t tab[$];
   vec_t r;

   initial begin
      reset = 1'b1;
      core_re = 0; core_we = 0; core_funct3 = 0;
      core_addr = 0; core_wdata = 0;
      mem_ack = 0; mem_rdata = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst req", 32'(mem_req), 0);
      chk("rst we", 32'(mem_we), 0);
      chk("rst done", 32'(done), 0);
      chk("rst to", 32'(timeout_err), 0);
      chk("rst addr", mem_addr, 0);
      chk("rst wdata", mem_wdata, 0);
      chk("rst rdata", core_rdata, 0);
      chk("rst wstrb", 32'(mem_wstrb), 0);
      chk("rst stall", 32'(stall), 0);
      reset = 1'b0;

      tab.push_back('{"lw64", 1, 0, 2, 32'h64, 0, 32'h19, 1,
                      0, 32'h0, 4'b0000, 32'h19});
      tab.push_back('{"sb61", 0, 1, 0, 32'h61, 32'hAB, 0, 4,
                      0, 32'hABABABAB, 4'b0010, 0});
      tab.push_back('{"lb62", 1, 0, 0, 32'h62, 0, 32'h12F03456, 2,
                      0, 0, 0, 32'hFFFFFFF0});
      tab.push_back('{"lbu62", 1, 0, 4, 32'h62, 0, 32'h12F03456, 1,
                      0, 0, 0, 32'h000000F0});
      tab.push_back('{"lh62", 1, 0, 1, 32'h62, 0, 32'h12F03456, 3,
                      0, 0, 0, 32'h000012F0});
      tab.push_back('{"lh60", 1, 0, 1, 32'h60, 0, 32'h00008001, 1,
                      0, 0, 0, 32'hFFFF8001});
      tab.push_back('{"lhu60", 1, 0, 5, 32'h60, 0, 32'h00008001, 1,
                      0, 0, 0, 32'h00008001});
      tab.push_back('{"sh62", 0, 1, 1, 32'h62, 32'h1234ABCD, 0, 2,
                      0, 32'hABCDABCD, 4'b1100, 0});
      tab.push_back('{"rwsb63", 1, 1, 0, 32'h63, 32'h5A, 0, 1,
                      0, 32'h5A5A5A5A, 4'b1000, 0});
      tab.push_back('{"lw66", 1, 0, 2, 32'h66, 0, 0, 1,
                      1, 0, 0, 0});
      tab.push_back('{"sh63", 0, 1, 1, 32'h63, 32'h1, 0, 1,
                      1, 0, 0, 0});
      tab.push_back('{"f3_011", 1, 0, 3, 32'h40, 0, 0, 1,
                      1, 0, 0, 0});
      tab.push_back('{"lw_to", 1, 0, 2, 32'h80, 0, 32'hDEADBEEF, 0,
                      0, 0, 0, 0});
      tab.push_back('{"sw84", 0, 1, 2, 32'h84, 32'hCAFEF00D, 0, 2,
                      0, 32'hCAFEF00D, 4'b1111, 0});
      tab.push_back('{"lw_ack8", 1, 0, 2, 32'h88, 0, 32'h13572468, TO,
                      0, 0, 0, 32'h13572468});
      foreach (tab[i]) access(tab[i]);

      // Reset in the second REQ cycle, then a late ack.
      @(negedge clk);
      core_re = 1; core_we = 0; core_funct3 = 2; core_addr = 32'h70;
      @(negedge clk);
      chk("rs req1", 32'(mem_req), 1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("rs req drop", 32'(mem_req), 0);
      chk("rs stall drop", 32'(stall), 0);
      core_re = 0;
      mem_ack = 1;
      mem_rdata = 32'h55;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rs no done", 32'(done), 0);
         chk("rs no req", 32'(mem_req), 0);
      end
      mem_ack = 0;
      access('{"rs_sw", 0, 1, 2, 32'h90, 32'h01020304, 0, 1,
               0, 32'h01020304, 4'b1111, 0});

      for (int n = 0; n < 60; n++) begin
         int k;
         k = int'($urandom_range(0, 2));
         r.nm   = "rand";
         r.re   = (k != 1);
         r.we   = (k != 0);
         r.f3   = ($urandom_range(0, 9) == 0) ? 3'($urandom)
                  : 3'($urandom_range(0, 2)) | ($urandom_range(0, 1)
                  ? 3'b100 : 3'b000);
         if (r.f3 == 3'b110) r.f3 = 3'b100;
         r.addr = $urandom;
         r.wd   = $urandom;
         r.rd   = $urandom;
         r.dly  = ($urandom_range(0, 7) == 0) ? 0
                  : int'($urandom_range(1, TO));
         model(r.re, r.we, r.f3, r.addr, r.wd, r.rd,
               r.emis, r.ewd, r.es, r.erd);
         access(r);
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/lsu_bridge.md
Name: lsu_bridge

Overview:
- Load/store unit between the single-cycle RV32I core's data port and a multi-cycle data memory (DDR3-style controller or wait-stated SRAM).
- Formats all RV32I load/store sizes: lb, lbu, lh, lhu, lw, sb, sh, sw. Stores produce byte strobes; loads are lane-extracted and sign/zero-extended.
- Drives a stall that freezes the core's PC register and register-file write until the memory transaction completes.
- Detects misaligned accesses and memory timeouts.

Parameters:
- TIMEOUT, 255: maximum REQ cycles without mem_ack before the access is aborted; range 1..65535.
- CNT_W, 16: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- core_re  in  1  current instruction is a load.
- core_we  in  1  current instruction is a store.
- core_funct3  in  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- core_addr  in  32  byte address, which is the ALU result.
- core_wdata  in  32  store data, which is rs2.
- core_rdata  out  32  extended load data, valid while done=1.
- stall  out  1  core must hold PC and suppress register write.
- done  out  1  one-cycle pulse; the access retires at this clock edge.
- misalign  out  1  combinational flag for a misaligned or illegal-size access.
- timeout_err  out  1  one-cycle pulse coincident with done when the access timed out.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word address, with byte address bits [1:0] forced to 00.
- mem_wdata  out  32  lane-replicated store data.
- mem_wstrb  out  4  byte enables; 0000 on reads.
- mem_ack  in  1  memory completion. mem_rdata is valid in the same cycle.
- mem_rdata  in  32  read word.

Behaviour:
- Reset values: FSM = IDLE. mem_req, mem_we, done, timeout_err = 0. mem_addr, mem_wdata, core_rdata = 0. mem_wstrb = 0000. The timeout counter = 0.
- Access: acc = core_re | core_we. If both are high, the access is treated as a store.
- Illegal/misaligned access: misalign = acc & (funct3 in {011,110,111} | (h/hu & addr[0]) | (w & addr[1:0] != 00)).
- A misaligned access issues no request, stall stays 0, and the instruction retires normally. Stores are dropped; load data returns 0.
- FSM has three states: IDLE, REQ, DONE.
- IDLE:
  - stall = acc & ~misalign, combinationally.
  - On that condition, at the clock edge: register mem_addr, mem_we, mem_wdata and mem_wstrb; set mem_req = 1; clear the counter; go to REQ.
- REQ:
  - stall = 1; mem_req = 1; the counter increments each cycle.
  - On mem_ack: capture the extended read data into core_rdata, drop mem_req, go to DONE.
  - If counter == TIMEOUT-1 and no mem_ack: drop mem_req, set core_rdata = 0, set the timeout_err flag, go to DONE.
  - mem_ack takes priority over timeout in the same cycle.
- DONE:
  - stall = 0, done = 1, timeout_err = 1 if the access timed out.
  - The core retires the instruction and the load result is written back at this edge. Go to IDLE unconditionally.
  - A new access is only evaluated in the next IDLE cycle.
- Latency: minimum 3 cycles (IDLE, REQ with ack, DONE). In general it is 2 + N REQ cycles.
- mem_ack outside REQ is ignored. Core inputs may change during REQ and are ignored, because the registered copies are used.
- Store formatting:
  - sb: wdata = {4{byte}}, wstrb = 0001 << addr[1:0].
  - sh: wdata = {2{half}}, wstrb = 0011 if addr[1] = 0, else 1100.
  - sw: wdata = rs2, wstrb = 1111.
- Load formatting:
  - Select the byte/half lane by the registered addr[1:0].
  - funct3[2] = 0 sign-extends; 1 zero-extends.
- Reset mid-access: immediate return to IDLE and mem_req = 0 asynchronously. Any in-flight ack after reset is ignored.

Test Plan:
- lw at 0x64 with ack on the 1st REQ cycle and mem_rdata = 0x00000019:
  - stall is high for 2 cycles; done pulses in the 3rd cycle.
  - core_rdata = 0x00000019, mem_wstrb = 0000.
- sb to 0x61 with rs2 = 0x000000AB and ack after 4 REQ cycles:
  - mem_addr = 0x60, mem_wdata = 0xABABABAB, mem_wstrb = 0010.
  - stall is high for 5 cycles.
- lb at 0x62 and lbu at 0x62 with mem_rdata = 0x12F0_3456:
  - lb gives core_rdata = 0xFFFFFFF0; lbu gives 0x000000F0.
  - lh at 0x62 gives 0x000012F0.
- Misaligned accesses:
  - lw at 0x66 or sh at 0x63: misalign = 1, mem_req is never asserted, stall = 0.
  - funct3 = 011: misalign = 1.
- Timeout with TIMEOUT = 8 and no ack:
  - mem_req is high for exactly 8 cycles.
  - done and timeout_err pulse together; core_rdata = 0.
  - The next access proceeds normally.
- Reset asserted in REQ cycle 2:
  - mem_req and stall drop without waiting for a clock edge.
  - A subsequent ack produces no done pulse; after reset release, an sw with ack completes with wstrb = 1111.
